// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I OP/OP-IMM/LUI/AUIPC decode and issue stage with two-entry skid buffer
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid_in,
    output logic            instr_ready_out,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [4:0]      rs1_addr_out,
    output logic [4:0]      rs2_addr_out,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    output logic            issue_valid_out,
    input  logic            issue_ready_in,
    output logic [3:0]      alu_op_out,
    output logic [XLEN-1:0] operand1_out,
    output logic [XLEN-1:0] operand2_out,
    output logic [4:0]      rd_addr_out,
    output logic            rd_we_out,
    output logic            illegal_out
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_PASS = 4'd10;

    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            we;
        logic            ill;
    } entry_t;

    entry_t dec, out_q, out_d, skid_q, skid_d;
    logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic   accept, drain;

    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_u, shamt_i, shamt_r;
    logic [3:0]      op;
    logic [XLEN-1:0] a, b;
    logic            legal;

    assign opc     = instr_in[6:0];
    assign f3      = instr_in[14:12];
    assign f7      = instr_in[31:25];
    assign imm_i   = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
    assign imm_u   = {instr_in[31:12], 12'b0};
    assign shamt_i = {{(XLEN-5){1'b0}}, instr_in[24:20]};
    assign shamt_r = {{(XLEN-5){1'b0}}, rs2_data_in[4:0]};

    assign rs1_addr_out = instr_in[19:15];
    assign rs2_addr_out = instr_in[24:20];

    always_comb begin
        op    = OP_PASS;
        a     = '0;
        b     = '0;
        legal = 1'b0;
        case (opc)
            7'b0110011: begin
                a = rs1_data_in;
                b = rs2_data_in;
                if (f7 == 7'b0000000) begin
                    legal = 1'b1;
                    case (f3)
                        3'b000:  op = OP_ADD;
                        3'b001:  op = OP_SLL;
                        3'b010:  op = OP_SLT;
                        3'b011:  op = OP_SLTU;
                        3'b100:  op = OP_XOR;
                        3'b101:  op = OP_SRL;
                        3'b110:  op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    legal = 1'b1;
                    op    = OP_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    legal = 1'b1;
                    op    = OP_SRA;
                end
                // ALU shifts by the whole operand2, so clip the register shift amount here
                if (op == OP_SLL || op == OP_SRL || op == OP_SRA)
                    b = shamt_r;
            end
            7'b0010011: begin
                a     = rs1_data_in;
                b     = imm_i;
                legal = 1'b1;
                case (f3)
                    3'b000: op = OP_ADD;
                    3'b010: op = OP_SLT;
                    3'b011: op = OP_SLTU;
                    3'b100: op = OP_XOR;
                    3'b110: op = OP_OR;
                    3'b111: op = OP_AND;
                    3'b001: begin
                        op    = OP_SLL;
                        b     = shamt_i;
                        legal = (f7 == 7'b0000000);
                    end
                    default: begin
                        b = shamt_i;
                        if (f7 == 7'b0000000)      op = OP_SRL;
                        else if (f7 == 7'b0100000) op = OP_SRA;
                        else                       legal = 1'b0;
                    end
                endcase
            end
            7'b0110111: begin
                legal = 1'b1;
                op    = OP_PASS;
                a     = imm_u;
            end
            7'b0010111: begin
                legal = 1'b1;
                op    = OP_ADD;
                a     = pc_in;
                b     = imm_u;
            end
            default: ;
        endcase
        dec.op  = legal ? op : OP_PASS;
        dec.a   = legal ? a : '0;
        dec.b   = legal ? b : '0;
        dec.rd  = instr_in[11:7];
        dec.we  = legal && (instr_in[11:7] != 5'd0);
        dec.ill = ~legal;
    end

    assign instr_ready_out = ~skid_valid_q & rst_n;
    assign accept          = instr_valid_in & instr_ready_out;
    assign drain           = out_valid_q & issue_ready_in;

    // Output register is always older than skid; skid refills output when output frees up
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = accept;
                if (accept) skid_d = dec;
            end else begin
                out_valid_d = accept;
                if (accept) out_d = dec;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign issue_valid_out = out_valid_q;
    assign alu_op_out      = out_q.op;
    assign operand1_out    = out_q.a;
    assign operand2_out    = out_q.b;
    assign rd_addr_out     = out_q.rd;
    assign rd_we_out       = out_q.we;
    assign illegal_out     = out_q.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed and randomized bench for alu_issue_stage with queue scoreboard
module tb_alu_issue_stage;
    logic        clk = 0;
    logic        rst_n;
    logic        instr_valid_in, instr_ready_out, issue_valid_out, issue_ready_in;
    logic [31:0] instr_in, pc_in, rs1_data_in, rs2_data_in, operand1_out, operand2_out;
    logic [4:0]  rs1_addr_out, rs2_addr_out, rd_addr_out;
    logic [3:0]  alu_op_out;
    logic        rd_we_out, illegal_out;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
        .instr_in(instr_in), .pc_in(pc_in),
        .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .issue_valid_out(issue_valid_out), .issue_ready_in(issue_ready_in),
        .alu_op_out(alu_op_out), .operand1_out(operand1_out), .operand2_out(operand2_out),
        .rd_addr_out(rd_addr_out), .rd_we_out(rd_we_out), .illegal_out(illegal_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t snap;
    logic held;
    int   n_tests = 0, n_fail = 0, issued = 0;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    // Expected issue entry computed from the ISA rules
    function automatic exp_t ref_dec(input logic [31:0] i, pc, r1, r2);
        exp_t        e;
        logic [3:0]  f3map [8] = '{4'd0, 4'd5, 4'd8, 4'd7, 4'd4, 4'd6, 4'd3, 4'd2};
        int          f3 = int'(i[14:12]);
        logic [6:0]  f7 = i[31:25];
        logic [31:0] simm = {{20{i[31]}}, i[31:20]};
        logic [31:0] uimm = 32'(i[31:12]) << 12;
        bit          legal = 0;
        e.op = 4'd10; e.a = 0; e.b = 0;
        case (i[6:0])
            7'h33: begin
                if (f7 == 0) begin legal = 1; e.op = f3map[f3]; end
                else if (f7 == 7'h20 && f3 == 0) begin legal = 1; e.op = 4'd1; end
                else if (f7 == 7'h20 && f3 == 5) begin legal = 1; e.op = 4'd9; end
                e.a = r1;
                e.b = (e.op inside {4'd5, 4'd6, 4'd9}) ? r2 % 32 : r2;
            end
            7'h13: begin
                e.a = r1; e.op = f3map[f3];
                if (f3 == 1 || f3 == 5) begin
                    e.b = 32'(i[24:20]);
                    legal = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
                    if (f3 == 5 && f7 == 7'h20) e.op = 4'd9;
                end else begin
                    legal = 1; e.b = simm;
                end
            end
            7'h37: begin legal = 1; e.op = 4'd10; e.a = uimm; e.b = 0; end
            7'h17: begin legal = 1; e.op = 4'd0; e.a = pc; e.b = uimm; end
            default: ;
        endcase
        if (!legal) begin e.op = 4'd10; e.a = 0; e.b = 0; end
        e.rd  = i[11:7];
        e.we  = legal && (i[11:7] != 0);
        e.ill = !legal;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] f7s;
        case ($urandom_range(0, 6))
            0: return enc_r(7'h00, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
            1: return enc_r($urandom_range(0, 1) ? 7'h20 : 7'($urandom), 5'($urandom), 5'($urandom),
                            3'($urandom), 5'($urandom));
            2: return enc_i(12'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h13);
            3: begin
                f7s = ($urandom_range(0, 2) == 0) ? 7'h00 : ($urandom_range(0, 1) ? 7'h20 : 7'($urandom));
                return enc_i({f7s, 5'($urandom)}, 5'($urandom), $urandom_range(0, 1) ? 3'd1 : 3'd5,
                             5'($urandom), 7'h13);
            end
            4: return enc_u(20'($urandom), 5'($urandom), 7'h37);
            5: return enc_u(20'($urandom), 5'($urandom), 7'h17);
            default: return $urandom;
        endcase
    endfunction

    // One clock: drive, observe at negedge against the scoreboard, then advance the model at posedge
    task automatic cycle(input logic v, input logic r, input logic [31:0] ins, pc, d1, d2, output logic acc);
        exp_t cur;
        logic xfer;
        instr_valid_in = v; issue_ready_in = r; instr_in = ins; pc_in = pc;
        rs1_data_in = d1; rs2_data_in = d2;
        @(negedge clk);
        cur = '{op: alu_op_out, a: operand1_out, b: operand2_out, rd: rd_addr_out, we: rd_we_out, ill: illegal_out};
        n_tests++;
        if (instr_ready_out !== (q.size() < 2)) begin
            n_fail++; $display("FAIL ready: got %b want %b", instr_ready_out, q.size() < 2);
        end
        n_tests++;
        if (issue_valid_out !== (q.size() > 0)) begin
            n_fail++; $display("FAIL issue_valid: got %b want %b", issue_valid_out, q.size() > 0);
        end
        n_tests++;
        if ({rs1_addr_out, rs2_addr_out} !== {ins[19:15], ins[24:20]}) begin
            n_fail++; $display("FAIL rs_addr: got %h/%h want %h/%h", rs1_addr_out, rs2_addr_out, ins[19:15], ins[24:20]);
        end
        if (held && issue_valid_out) begin
            n_tests++;
            if (cur !== snap) begin
                n_fail++; $display("FAIL hold_stable: got %h want %h", cur, snap);
            end
        end
        acc  = v & instr_ready_out;
        xfer = issue_valid_out & r;
        if (xfer && q.size() > 0) begin
            n_tests++;
            if (cur !== q[0]) begin
                n_fail++; $display("FAIL issue_entry: got %h want %h", cur, q[0]);
            end
        end
        snap = cur;
        held = issue_valid_out & ~r;
        @(posedge clk);
        if (xfer && q.size() > 0) begin void'(q.pop_front()); issued++; end
        if (acc) q.push_back(ref_dec(ins, pc, d1, d2));
        #1;
    endtask

    task automatic drain();
        logic acc;
        repeat (4) cycle(0, 1, 32'h0, 32'h0, 32'h0, 32'h0, acc);
    endtask

    task automatic test_reset();
        rst_n = 0; instr_valid_in = 0; issue_ready_in = 0; instr_in = 0; pc_in = 0;
        rs1_data_in = 0; rs2_data_in = 0; held = 0;
        #3;
        n_tests++;
        if ({instr_ready_out, issue_valid_out, alu_op_out, operand1_out, operand2_out, rd_addr_out, rd_we_out, illegal_out} !== '0) begin
            n_fail++; $display("FAIL reset_state: got rdy=%b vld=%b op=%0d a=%h b=%h", instr_ready_out, issue_valid_out, alu_op_out, operand1_out, operand2_out);
        end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        n_tests++;
        if ({instr_ready_out, issue_valid_out} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release: got rdy=%b vld=%b want 1/0", instr_ready_out, issue_valid_out);
        end
    endtask

    task automatic test_add();
        logic acc;
        drain();
        cycle(1, 1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0, 32'd5, 32'd7, acc);
        n_tests++;
        if ({acc, issue_valid_out, alu_op_out, operand1_out, operand2_out, rd_addr_out, rd_we_out, illegal_out}
            !== {1'b1, 1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL add: got op=%0d a=%h b=%h rd=%0d we=%b want 0/5/7/3/1", alu_op_out, operand1_out, operand2_out, rd_addr_out, rd_we_out);
        end
    endtask

    task automatic test_shifts();
        logic acc;
        cycle(1, 1, enc_i({7'h20, 5'd31}, 5'd1, 3'd5, 5'd4, 7'h13), 32'h0, 32'h8000_0000, 32'h0, acc);
        n_tests++;
        if ({alu_op_out, operand1_out, operand2_out, rd_addr_out, rd_we_out, illegal_out}
            !== {4'd9, 32'h8000_0000, 32'd31, 5'd4, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL srai: got op=%0d b=%h want 9/1f", alu_op_out, operand2_out);
        end
        cycle(1, 1, enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd5), 32'h0, 32'h11, 32'h123, acc);
        n_tests++;
        if ({alu_op_out, operand1_out, operand2_out, rd_addr_out, rd_we_out} !== {4'd5, 32'h11, 32'd3, 5'd5, 1'b1}) begin
            n_fail++; $display("FAIL sll: got op=%0d b=%h want 5/3", alu_op_out, operand2_out);
        end
        cycle(1, 1, enc_i({7'h01, 5'd3}, 5'd1, 3'd1, 5'd6, 7'h13), 32'h0, 32'h11, 32'h0, acc);
        n_tests++;
        if ({alu_op_out, operand1_out, operand2_out, rd_addr_out, rd_we_out, illegal_out}
            !== {4'd10, 32'd0, 32'd0, 5'd6, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL slli_bad: got op=%0d ill=%b we=%b want 10/1/0", alu_op_out, illegal_out, rd_we_out);
        end
    endtask

    task automatic test_upper();
        logic acc;
        cycle(1, 1, enc_u(20'hABCDE, 5'd6, 7'h37), 32'h0, 32'h1234, 32'h5678, acc);
        n_tests++;
        if ({alu_op_out, operand1_out, operand2_out, rd_addr_out, rd_we_out} !== {4'd10, 32'hABCDE000, 32'd0, 5'd6, 1'b1}) begin
            n_fail++; $display("FAIL lui: got op=%0d a=%h b=%h", alu_op_out, operand1_out, operand2_out);
        end
        cycle(1, 1, enc_u(20'h00001, 5'd7, 7'h17), 32'h100, 32'h1234, 32'h5678, acc);
        n_tests++;
        if ({alu_op_out, operand1_out, operand2_out, rd_addr_out, rd_we_out} !== {4'd0, 32'h100, 32'h1000, 5'd7, 1'b1}) begin
            n_fail++; $display("FAIL auipc: got op=%0d a=%h b=%h", alu_op_out, operand1_out, operand2_out);
        end
        cycle(1, 1, enc_i(12'd1, 5'd0, 3'd0, 5'd0, 7'h13), 32'h0, 32'h55, 32'h0, acc);
        n_tests++;
        if ({alu_op_out, operand1_out, operand2_out, rd_addr_out, rd_we_out, illegal_out}
            !== {4'd0, 32'h55, 32'd1, 5'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL addi_x0: got we=%b rd=%0d b=%h want 0/0/1", rd_we_out, rd_addr_out, operand2_out);
        end
    endtask

    task automatic test_illegal_load();
        logic acc;
        cycle(1, 1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd8), 32'h0, 32'd1, 32'd2, acc);
        cycle(1, 1, enc_i(12'd4, 5'd2, 3'd2, 5'd9, 7'h03), 32'h0, 32'hDEAD, 32'hBEEF, acc);
        n_tests++;
        if ({issue_valid_out, alu_op_out, operand1_out, operand2_out, rd_addr_out, rd_we_out, illegal_out}
            !== {1'b1, 4'd10, 32'd0, 32'd0, 5'd9, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL load_illegal: got op=%0d a=%h b=%h rd=%0d we=%b ill=%b", alu_op_out, operand1_out, operand2_out, rd_addr_out, rd_we_out, illegal_out);
        end
        cycle(1, 1, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd10), 32'h0, 32'd9, 32'd4, acc);
        n_tests++;
        if ({alu_op_out, rd_addr_out, illegal_out} !== {4'd1, 5'd10, 1'b0}) begin
            n_fail++; $display("FAIL after_illegal: got op=%0d rd=%0d want 1/10", alu_op_out, rd_addr_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog [4];
        int   idx = 0, cyc = 0, start;
        logic acc;
        drain();
        start = issued;
        prog[0] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd11);
        prog[1] = enc_r(7'h20, 5'd3, 5'd4, 3'd0, 5'd12);
        prog[2] = enc_i(12'hF0F, 5'd5, 3'd4, 5'd13, 7'h13);
        prog[3] = enc_u(20'h12345, 5'd14, 7'h37);
        while (idx < 4 && cyc < 20) begin
            cycle(1, cyc >= 3, prog[idx], 32'h40, $urandom, $urandom, acc);
            if (acc) idx++;
            if (cyc == 1) begin
                n_tests++;
                if ({instr_ready_out, issue_valid_out} !== 2'b01) begin
                    n_fail++; $display("FAIL skid_full: got rdy=%b vld=%b want 0/1", instr_ready_out, issue_valid_out);
                end
            end
            cyc++;
        end
        drain();
        n_tests++;
        if (issued - start != 4 || idx != 4) begin
            n_fail++; $display("FAIL stream_count: got %0d issued %0d accepted want 4/4", issued - start, idx);
        end
    endtask

    task automatic test_reset_midflight();
        logic acc;
        drain();
        cycle(1, 0, enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd15), 32'h0, $urandom, $urandom, acc);
        cycle(1, 0, enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd16), 32'h0, $urandom, $urandom, acc);
        instr_valid_in = 0;
        rst_n = 0;
        #1;
        n_tests++;
        if ({instr_ready_out, issue_valid_out, alu_op_out, operand1_out, operand2_out, rd_addr_out, rd_we_out, illegal_out} !== '0) begin
            n_fail++; $display("FAIL reset_async: got rdy=%b vld=%b op=%0d rd=%0d", instr_ready_out, issue_valid_out, alu_op_out, rd_addr_out);
        end
        q.delete(); held = 0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        n_tests++;
        if ({instr_ready_out, issue_valid_out} !== 2'b10) begin
            n_fail++; $display("FAIL reset_after: got rdy=%b vld=%b want 1/0", instr_ready_out, issue_valid_out);
        end
    endtask

    task automatic test_random();
        logic acc;
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rand_instr(), $urandom, $urandom, $urandom, acc);
        drain();
        n_tests++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL random_drain: got %0d left want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shifts();
        test_upper();
        test_illegal_load();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
